// File: rtl/parammod_arb_pkg.sv
// parammod_arb_pkg: shared state encoding and active-level macros for the lock arbiter.
`ifndef HIGH
`define HIGH 1'b1
`endif
`ifndef LOW
`define LOW 1'b0
`endif
package parammod_arb_pkg;
   typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
endpackage

// File: rtl/lock_rr_arbiter_bin_dec.sv
// bin_dec: binary index to one-hot decoder at selectable active level.
`ifndef HIGH
`define HIGH 1'b1
`endif
`ifndef LOW
`define LOW 1'b0
`endif
module bin_dec #(
   parameter int   IN  = 3,
   parameter logic ACT = `HIGH
) (
   input  logic [IN-1:0]      bin,
   output logic [(1<<IN)-1:0] dec
);
   localparam int REQ = 1 << IN;
   assign dec = ACT ? (REQ'(1) << bin) : ~(REQ'(1) << bin);
endmodule

// File: rtl/lock_rr_arbiter.sv
// lock_rr_arbiter: round-robin arbiter whose winner keeps the grant until it drops its request.
`ifndef HIGH
`define HIGH 1'b1
`endif
`ifndef LOW
`define LOW 1'b0
`endif
module lock_rr_arbiter
   import parammod_arb_pkg::*;
#(
   parameter int   IN  = 3,
   parameter logic ACT = `HIGH
) (
   input  logic                clk,
   input  logic                reset_,
   input  logic [(1<<IN)-1:0]  req,
   output logic [(1<<IN)-1:0]  grant,
   output logic [IN-1:0]       grant_id,
   output logic                grant_valid
);
   localparam int REQ = 1 << IN;
   arb_state_t     state, state_n;
   logic [IN-1:0]  ptr, ptr_n, gid_n;
   logic [REQ-1:0] act, own, dec;
   logic [IN:0]    pick;
   // Returns {found, index} of the first set bit of v searching start, start+1, ... with wrap.
   function automatic logic [IN:0] rr_pick(input logic [REQ-1:0] v, input logic [IN-1:0] start);
      logic [IN:0]   r;
      logic [IN-1:0] k;
      r = '0;
      for (int i = REQ - 1; i >= 0; i--) begin
         k = start + IN'(i);
         if (v[k]) r = {1'b1, k};
      end
      return r;
   endfunction
   assign act = req ~^ {REQ{ACT}};
   assign own = REQ'(1) << grant_id;
   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      gid_n   = grant_id;
      pick    = '0;
      if (state == ARB_IDLE) begin
         pick = rr_pick(act, ptr);
         if (pick[IN]) begin
            state_n = ARB_GRANT;
            gid_n   = pick[IN-1:0];
         end
      end else if (!act[grant_id]) begin
         ptr_n   = grant_id + 1'b1;
         pick    = rr_pick(act & ~own, ptr_n);
         state_n = pick[IN] ? ARB_GRANT : ARB_IDLE;
         gid_n   = pick[IN] ? pick[IN-1:0] : grant_id;
      end
   end
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state    <= ARB_IDLE;
         ptr      <= '0;
         grant_id <= '0;
      end else begin
         state    <= state_n;
         ptr      <= ptr_n;
         grant_id <= gid_n;
      end
   end
   assign grant_valid = (state == ARB_GRANT);
   bin_dec #(.IN(IN), .ACT(ACT)) u_dec (.bin(grant_id), .dec(dec));
   assign grant = grant_valid ? dec : {REQ{~ACT}};
endmodule

// File: tb/tb_lock_rr_arbiter.sv
// tb_lock_rr_arbiter: directed vector table plus active-low polarity sequence.
`ifndef HIGH
`define HIGH 1'b1
`endif
`ifndef LOW
`define LOW 1'b0
`endif
module tb_lock_rr_arbiter;
   typedef struct {
      logic       rst;
      logic [7:0] req;
      logic [7:0] grant;
      logic [2:0] id;
      logic       valid;
   } vec_t;
   logic       clk = 1'b0;
   logic       reset_ = 1'b0;
   logic [7:0] req = 8'h00, req_l = 8'hFF;
   logic [7:0] grant, grant_l;
   logic [2:0] grant_id, grant_id_l;
   logic       grant_valid, grant_valid_l;
   int         total = 0, bad = 0;
   vec_t       vt[24];
   lock_rr_arbiter #(.IN(3), .ACT(`HIGH)) dut (
      .clk(clk), .reset_(reset_), .req(req),
      .grant(grant), .grant_id(grant_id), .grant_valid(grant_valid)
   );
   lock_rr_arbiter #(.IN(3), .ACT(`LOW)) dut_l (
      .clk(clk), .reset_(reset_), .req(req_l),
      .grant(grant_l), .grant_id(grant_id_l), .grant_valid(grant_valid_l)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
   endtask
   initial begin
      // rst=1 rows pull reset_ low and check without a clock edge.
      vt[0]  = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0};
      vt[1]  = '{1'b0, 8'h10, 8'h10, 3'd4, 1'b1};
      vt[2]  = '{1'b0, 8'h10, 8'h10, 3'd4, 1'b1};
      vt[3]  = '{1'b0, 8'h10, 8'h10, 3'd4, 1'b1};
      vt[4]  = '{1'b0, 8'h10, 8'h10, 3'd4, 1'b1};
      vt[5]  = '{1'b0, 8'h10, 8'h10, 3'd4, 1'b1};
      vt[6]  = '{1'b0, 8'h00, 8'h00, 3'd4, 1'b0};
      vt[7]  = '{1'b0, 8'h00, 8'h00, 3'd4, 1'b0};
      vt[8]  = '{1'b1, 8'h81, 8'h00, 3'd0, 1'b0};
      vt[9]  = '{1'b0, 8'h81, 8'h01, 3'd0, 1'b1};
      vt[10] = '{1'b0, 8'h80, 8'h80, 3'd7, 1'b1};
      vt[11] = '{1'b0, 8'h01, 8'h01, 3'd0, 1'b1};
      vt[12] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0};
      vt[13] = '{1'b0, 8'h04, 8'h04, 3'd2, 1'b1};
      vt[14] = '{1'b0, 8'h0D, 8'h04, 3'd2, 1'b1};
      vt[15] = '{1'b0, 8'h09, 8'h08, 3'd3, 1'b1};
      vt[16] = '{1'b0, 8'h01, 8'h01, 3'd0, 1'b1};
      vt[17] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0};
      vt[18] = '{1'b0, 8'h08, 8'h08, 3'd3, 1'b1};
      vt[19] = '{1'b1, 8'h08, 8'h00, 3'd0, 1'b0};
      vt[20] = '{1'b0, 8'hFF, 8'h01, 3'd0, 1'b1};
      vt[21] = '{1'b0, 8'hFE, 8'h02, 3'd1, 1'b1};
      vt[22] = '{1'b0, 8'hFE, 8'h02, 3'd1, 1'b1};
      vt[23] = '{1'b0, 8'h01, 8'h01, 3'd0, 1'b1};
      #1;
      for (int i = 0; i < 24; i++) begin
         req = vt[i].req;
         if (vt[i].rst) begin
            reset_ = 1'b0;
            #1;
         end else begin
            @(posedge clk);
            #1;
         end
         chk($sformatf("v%0d grant", i), 32'(grant), 32'(vt[i].grant));
         chk($sformatf("v%0d id", i), 32'(grant_id), 32'(vt[i].id));
         chk($sformatf("v%0d valid", i), 32'(grant_valid), 32'(vt[i].valid));
         if (vt[i].rst) begin
            #1;
            reset_ = 1'b1;
         end
      end
      req = 8'h00;
      reset_ = 1'b0;
      #1;
      chk("low rst grant", 32'(grant_l), 32'h FF);
      chk("low rst valid", 32'(grant_valid_l), 32'h0);
      #1;
      reset_ = 1'b1;
      req_l = 8'hFB;
      @(posedge clk);
      #1;
      chk("low grant", 32'(grant_l), 32'hFB);
      chk("low id", 32'(grant_id_l), 32'd2);
      chk("low valid", 32'(grant_valid_l), 32'h1);
      req_l = 8'hFF;
      @(posedge clk);
      #1;
      chk("low idle grant", 32'(grant_l), 32'hFF);
      chk("low idle valid", 32'(grant_valid_l), 32'h0);
      chk("low idle id", 32'(grant_id_l), 32'd2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/lock_rr_arbiter.md
LOCK_RR_ARBITER -- requirements
Module: lock_rr_arbiter

Interface
REQ-001: Parameter IN, default 3, is the width of the requester index; the requester count is REQ = 1 << IN.
REQ-002: Parameter ACT, default `HIGH, is the active level of every bit of req and grant.
REQ-003: clk  input  1  single clock; all state updates on the rising edge.
REQ-004: reset_  input  1  asynchronous, active-low reset.
REQ-005: req  input  REQ  per-requester request; a bit equal to ACT means "requesting / holding the resource".
REQ-006: grant  output  REQ  one-hot grant at polarity ACT; all bits are ~ACT when grant_valid is 0.
REQ-007: grant_id  output  IN  binary index of the current or last owner.
REQ-008: grant_valid  output  1  active-high; 1 means the resource is owned by requester grant_id.

Function
REQ-009: The FSM shall have exactly two states, ARB_IDLE and ARB_GRANT.
REQ-010: Priority pointer ptr (IN bits) shall name the highest-priority index; the search order is ptr, ptr+1, ..., ptr-1 modulo REQ.
REQ-011: In ARB_IDLE with at least one req bit at ACT, the FSM shall pick the first active index in search order, register it in grant_id, set grant_valid=1, and enter ARB_GRANT at the same edge; grant latency is 1 cycle.
REQ-012: In ARB_IDLE with no active req, the FSM shall stay in ARB_IDLE with grant_valid=0 and ptr unchanged.
REQ-013: In ARB_GRANT, while req[grant_id] equals ACT, grant_id, grant and state shall hold (lock), regardless of other requests.
REQ-014: In ARB_GRANT, when req[grant_id] is ~ACT (release), at that edge ptr shall become grant_id+1 (wrapping from REQ-1 to 0).
REQ-015: At a release, if any other req bit is active, the arbiter shall grant the first such index searching from grant_id+1, excluding grant_id, and stay in ARB_GRANT: a back-to-back handover with no idle cycle.
REQ-016: At a release with no other active request, the FSM shall enter ARB_IDLE and grant_valid shall be 0 on the next cycle.
REQ-017: A requester that re-asserts req in the same cycle it releases shall not regain the grant at that edge; it is eligible again from the following cycle.
REQ-018: grant shall be the decode of grant_id at polarity ACT, gated by grant_valid, so that it is never multi-hot.
REQ-019: grant_id shall retain its last value while grant_valid is 0.
REQ-020: Index arithmetic shall be IN-bit unsigned, with natural wrap-around.

Reset
REQ-021: When reset_ is 0, the block shall asynchronously force state=ARB_IDLE, ptr=0, grant_id=0, grant_valid=0, and all grant bits to ~ACT, including in the middle of an ownership.
REQ-022: The first arbitration after reset deassertion shall search from index 0.

Structure
REQ-023: Package parammod_arb_pkg shall hold the enum arb_state_t {ARB_IDLE, ARB_GRANT}; `HIGH/`LOW shall come from parammod_stddef.vh.
REQ-024: The grant vector shall be produced by one bin_dec instance (IN=IN, ACT=ACT) driven by grant_id, with its output masked by grant_valid.
REQ-025: The circular priority search shall be a combinational function within lock_rr_arbiter, with no further sub-modules.

Verification (IN=3, ACT=`HIGH unless stated)
REQ-026: Reset: reset_=0 -> grant=8'h00, grant_valid=0, grant_id=0 with no clock edge required.
REQ-027: Single requester: req=8'h10 -> next cycle grant=8'h10, grant_id=4, valid=1, held for 5 cycles; req=8'h00 -> next cycle valid=0, grant=8'h00, grant_id stays 4.
REQ-028: Back-to-back and wrap: req=8'h81 from reset -> grant id 0; drop bit0 (req=8'h80) -> next cycle id 7, no idle cycle; then req=8'h01 -> next cycle id 0.
REQ-029: Fairness: with id 2 owned and req=8'h0D, drop bit2 (req=8'h09) -> grant id 3, not 0; then drop bit3 -> grant id 0.
REQ-030: Reset mid-grant: reset_ pulled low while grant=8'h08 -> grant=8'h00 immediately; after release, req=8'hFF -> grant id 0.
REQ-031: Polarity ACT=`LOW: req=8'hFB -> grant=8'hFB, grant_id=2; idle state -> grant=8'hFF.
